// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the hazard scoreboard: CSR indices,
// register-file sizes and the destination descriptor used on issue and retire.
package hazard_scoreboard_pkg;

  localparam logic [1:0] MCAUSE  = 2'b00;
  localparam logic [1:0] MEPC    = 2'b01;
  localparam logic [1:0] MSTATUS = 2'b10;
  localparam logic [1:0] MTVEC   = 2'b11;

  localparam int NUM_GPR = 32;
  localparam int NUM_CSR = 4;

  typedef struct packed {
    logic [4:0] rd;
    logic       rd_en;
    logic [1:0] csr_rd;
    logic       csr_en;
  } sb_dest_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Issue/retire/query bundle between decode, writeback and the hazard scoreboard.
// master: pipeline side that drives fires and queries; slave: the scoreboard.
interface hazard_scoreboard_if #(parameter int CNT_W = 2);
  logic             issue_fire;
  logic [4:0]       issue_rd;
  logic             issue_rd_en;
  logic [1:0]       issue_csr_rd;
  logic             issue_csr_en;
  logic             retire_fire;
  logic [4:0]       retire_rd;
  logic             retire_rd_en;
  logic [1:0]       retire_csr_rd;
  logic             retire_csr_en;
  logic [4:0]       q_rs1;
  logic [4:0]       q_rs2;
  logic             q_rs1_en;
  logic             q_rs2_en;
  logic [1:0]       q_csr_rs;
  logic             q_csr_en;
  logic             stall;
  logic             issue_ok;
  logic [CNT_W-1:0] inflight;
  logic             sb_err;

  modport master (
    output issue_fire, issue_rd, issue_rd_en, issue_csr_rd, issue_csr_en,
    output retire_fire, retire_rd, retire_rd_en, retire_csr_rd, retire_csr_en,
    output q_rs1, q_rs2, q_rs1_en, q_rs2_en, q_csr_rs, q_csr_en,
    input  stall, issue_ok, inflight, sb_err
  );

  modport slave (
    input  issue_fire, issue_rd, issue_rd_en, issue_csr_rd, issue_csr_en,
    input  retire_fire, retire_rd, retire_rd_en, retire_csr_rd, retire_csr_en,
    input  q_rs1, q_rs2, q_rs1_en, q_rs2_en, q_csr_rs, q_csr_en,
    output stall, issue_ok, inflight, sb_err
  );
endinterface

// File: rtl/hazard_scoreboard_sb_counter.sv
// Saturating up/down counter: holds at SAT on increment and at 0 on decrement,
// pulsing o_err in either case. Simultaneous inc and dec cancel out.
module sb_counter #(
  parameter int               CNT_W = 2,
  parameter logic [CNT_W-1:0] SAT   = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_zero,
  output logic             o_err
);
  logic [CNT_W-1:0] r_cnt;
  logic             w_full;
  logic             w_up;
  logic             w_dn;

  assign o_zero = (r_cnt == '0);
  assign w_full = (r_cnt == SAT);
  assign w_up   = i_inc && !i_dec;
  assign w_dn   = i_dec && !i_inc;
  assign o_err  = (w_up && w_full) || (w_dn && o_zero);
  assign o_cnt  = r_cnt;

  always_ff @(posedge clk) begin
    if (rst)                  r_cnt <= '0;
    else if (w_up && !w_full) r_cnt <= r_cnt + CNT_W'(1);
    else if (w_dn && !o_zero) r_cnt <= r_cnt - CNT_W'(1);
  end
endmodule

// File: rtl/hazard_scoreboard.sv
// Counted pending-write scoreboard for 31 GPRs and 4 CSRs plus an in-flight limiter.
// Optional HAZARD_SB_ERR_EN: sticky sb_err and simulation assertions on protocol errors.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int MAX_INFLIGHT = 3,
  parameter int CNT_W        = 2
) (
  input logic          clk,
  input logic          rst,
  hazard_scoreboard_if.slave sb
);
  sb_dest_t                          w_iss, w_ret;
  logic                              w_issue_ok, w_iss_go;
  logic [NUM_GPR-1:1]                w_gpr_zero, w_gpr_err;
  logic [NUM_GPR-1:1][CNT_W-1:0]     w_gpr_cnt;
  logic [NUM_GPR-1:0]                w_gpr_free;
  logic [NUM_CSR-1:0]                w_csr_zero, w_csr_err;
  logic [NUM_CSR-1:0][CNT_W-1:0]     w_csr_cnt;
  logic [CNT_W-1:0]                  w_inf_cnt;
  logic                              w_inf_zero, w_inf_err;
  logic                              w_err, w_unused_cnt;

  assign w_iss = {sb.issue_rd, sb.issue_rd_en, sb.issue_csr_rd, sb.issue_csr_en};
  assign w_ret = {sb.retire_rd, sb.retire_rd_en, sb.retire_csr_rd, sb.retire_csr_en};

  // An issue accepted while full is dropped so destination counts stay consistent.
  assign w_iss_go = sb.issue_fire && w_issue_ok;

  for (genvar g = 1; g < NUM_GPR; g++) begin : g_gpr
    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk, .rst,
      .i_inc  (w_iss_go && w_iss.rd_en && (w_iss.rd == 5'(g))),
      .i_dec  (sb.retire_fire && w_ret.rd_en && (w_ret.rd == 5'(g))),
      .o_cnt  (w_gpr_cnt[g]),
      .o_zero (w_gpr_zero[g]),
      .o_err  (w_gpr_err[g])
    );
  end

  for (genvar c = 0; c < NUM_CSR; c++) begin : g_csr
    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk, .rst,
      .i_inc  (w_iss_go && w_iss.csr_en && (w_iss.csr_rd == 2'(c))),
      .i_dec  (sb.retire_fire && w_ret.csr_en && (w_ret.csr_rd == 2'(c))),
      .o_cnt  (w_csr_cnt[c]),
      .o_zero (w_csr_zero[c]),
      .o_err  (w_csr_err[c])
    );
  end

  sb_counter #(.CNT_W(CNT_W), .SAT(CNT_W'(MAX_INFLIGHT))) u_inflight (
    .clk, .rst,
    .i_inc  (sb.issue_fire),
    .i_dec  (sb.retire_fire),
    .o_cnt  (w_inf_cnt),
    .o_zero (w_inf_zero),
    .o_err  (w_inf_err)
  );

  // x0 is always free, so reads of it never stall.
  assign w_gpr_free = {w_gpr_zero, 1'b1};
  assign w_issue_ok = (w_inf_cnt < CNT_W'(MAX_INFLIGHT));

  assign sb.issue_ok = w_issue_ok;
  assign sb.inflight = w_inf_cnt;
  assign sb.stall    = (sb.q_rs1_en && !w_gpr_free[sb.q_rs1]) ||
                       (sb.q_rs2_en && !w_gpr_free[sb.q_rs2]) ||
                       (sb.q_csr_en && !w_csr_zero[sb.q_csr_rs]) ||
                       !w_issue_ok;

  assign w_err = (|w_gpr_err) || (|w_csr_err) || w_inf_err ||
                 (sb.issue_fire && !w_issue_ok);
  assign w_unused_cnt = ^{w_gpr_cnt, w_csr_cnt, w_inf_zero};

`ifdef HAZARD_SB_ERR_EN
  logic r_sb_err;
  always_ff @(posedge clk) begin
    if (rst)        r_sb_err <= 1'b0;
    else if (w_err) r_sb_err <= 1'b1;
  end
  assign sb.sb_err = r_sb_err;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(sb.issue_fire && !w_issue_ok))
        else $warning("hazard_scoreboard: issue while in-flight limit reached");
      assert (!((|w_gpr_err) || (|w_csr_err)))
        else $warning("hazard_scoreboard: register counter saturated or underflowed");
      assert (!(w_inf_err && w_issue_ok))
        else $warning("hazard_scoreboard: retire with nothing in flight");
    end
  end
`endif
`else
  logic w_unused_err;
  assign w_unused_err = w_err;
  assign sb.sb_err    = 1'b0;
`endif
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Tracks the destination registers of every instruction the decode stage has issued but writeback has not yet retired. From that it produces a stall signal that holds decode until all of the current instruction's source operands are stable. It sits beside `idu` and replaces per-stage rd comparison against exu/lsu/wbu state with counted pending writes for the 32 GPRs and the 4 CSRs (2-bit CSR index). It also limits how many instructions can be in flight between issue and retire.

## Interface
Parameters:
- `MAX_INFLIGHT`, 3: maximum number of issued, not-yet-retired instructions.
- `CNT_W`, 2: width of each per-register pending counter; must satisfy 2^CNT_W > MAX_INFLIGHT.

Ports (clock and reset first; one clock, reset synchronous and active-high):
- `clk` input 1: clock.
- `rst` input 1: synchronous active-high reset.
- `issue_fire` input 1: decode handshake completed (`idu_send_valid && idu_receive_ready`).
- `issue_rd` input 5: destination GPR of the issued instruction.
- `issue_rd_en` input 1: issued instruction writes a GPR.
- `issue_csr_rd` input 2: destination CSR index.
- `issue_csr_en` input 1: issued instruction writes a CSR.
- `retire_fire` input 1: writeback completed for the oldest in-flight instruction.
- `retire_rd`, `retire_rd_en`, `retire_csr_rd`, `retire_csr_en` inputs 5/1/2/1: the retiring instruction's destinations.
- `q_rs1`, `q_rs2` input 5: sources of the instruction waiting in decode.
- `q_rs1_en`, `q_rs2_en` input 1: the corresponding source is actually read.
- `q_csr_rs` input 2, `q_csr_en` input 1: CSR source and its enable.
- `stall` output 1: decode must not assert send-valid this cycle.
- `issue_ok` output 1: in-flight count is below `MAX_INFLIGHT`.
- `inflight` output CNT_W: current in-flight count.
- `sb_err` output 1: sticky protocol error (see Configuration).

## Operation
- State: `gpr_cnt[1..31]` and `csr_cnt[0..3]`, each CNT_W bits; `inflight_cnt` CNT_W bits. Register x0 is never tracked: writes to x0 are ignored, and reads of x0 never stall.
- Issue with the matching enable set and rd≠0: `gpr_cnt[issue_rd]` +1. The same rule applies to `csr_cnt[issue_csr_rd]` with `issue_csr_en`.
- Retire with the matching enable set: the matching counter −1.
- Issue and retire to the same counter in the same cycle: the counter is unchanged.
- `inflight_cnt`: +1 on `issue_fire`, −1 on `retire_fire`, unchanged when both fire. Retires occur in issue order, so the count is exact.
- `stall` = (q_rs1_en && q_rs1≠0 && gpr_cnt[q_rs1]≠0) || (q_rs2_en && q_rs2≠0 && gpr_cnt[q_rs2]≠0) || (q_csr_en && csr_cnt[q_csr_rs]≠0) || !issue_ok.
- `issue_ok` = inflight_cnt < MAX_INFLIGHT.
- Issue while `!issue_ok`, or an increment of a saturated counter: the counter holds its value and the error flag is set.
- Retire of a zero counter, or `retire_fire` with inflight 0: the counter holds at 0 and the error flag is set.

## Timing
- `stall`, `issue_ok` and `inflight` are combinational from registered counters only. An issue or retire becomes visible in `stall` the cycle after its fire cycle; there is no same-cycle retire bypass.
- A back-to-back dependent pair therefore stalls until at least one cycle after the producer's `retire_fire`.
- Reset: all counters 0, `inflight`=0, `stall`=0 when no source is enabled, `issue_ok`=1, `sb_err`=0.
- Reset asserted mid-operation discards all pending state; the pipeline must be flushed by the same reset.
- Wrap-around never occurs: counters saturate and the error is flagged.

## Configuration
- `HAZARD_SB_ERR_EN` defined:
  - Error detection logic is present, and `sb_err` latches until `rst`.
  - Simulation assertions fire on each error condition.
- `HAZARD_SB_ERR_EN` undefined:
  - `sb_err` is tied to 0 and there are no assertions.
  - Counter update arithmetic is identical apart from the error flag, including saturation and hold-at-zero.

## Structure
- The shared package holds:
  - CSR index constants: MCAUSE=2'b00, MEPC=2'b01, MSTATUS=2'b10, MTVEC=2'b11.
  - `NUM_GPR`=32 and `NUM_CSR`=4.
  - A packed struct `sb_dest_t` with fields {rd, rd_en, csr_rd, csr_en}, used on both the issue and the retire side.
- One sub-module, `sb_counter`: a CNT_W-bit saturating up/down counter with inc, dec, a zero flag and an error pulse. It is instantiated 31 times for the GPRs, 4 times for the CSRs, and once for inflight.

## Test plan
- Issue rd=5 with en; next cycle query rs1=5 with en → stall=1. Retire rd=5 → stall=0 the cycle after the retire.
- Issue rd=0 with en, then query rs1=0 → stall=0 throughout, and no counter changes.
- Issue rd=7 twice (inflight=2), then retire once → gpr_cnt[7]=1 and stall stays 1; second retire → stall=0.
- Issue rd=3 and retire rd=3 in the same cycle while cnt=1 → cnt stays 1, inflight unchanged.
- Issue 3 instructions with no retire → issue_ok=0 and stall=1 with no sources enabled. A 4th issue → sb_err=1 with the macro defined, 0 without.
- Issue a CSR write to MEPC (2'b01), then query csr_rs=01 → stall=1; query csr_rs=11 → stall=0. Assert rst → all counts 0 and stall=0.
